// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_LAT       = 4;
    localparam int unsigned WORDS_PER_BLK = 8;
    localparam logic [15:0] BLK_MASK      = 16'hFFF0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: serves write-through stores and 8-word cache block
// fills (I-side and D-side) over one pipelined, multi-cycle memory port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [15:0]       d_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic              fill_we,
    output logic              fill_sel,
    output logic [2:0]        fill_word,
    output logic [15:0]       fill_data,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              d_wr_ack,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(2 * WORDS_PER_BLK - 1);
    localparam logic [2:0]        LAST_WORD = 3'(WORDS_PER_BLK - 1);

    arb_state_t        state, state_nxt;
    req_t              grant;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [2:0]        issue_cnt;
    logic              issue_done;
    logic [2:0]        recv_cnt;

    // State register; reset aborts any service in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: fixed priority in IDLE, no preemption elsewhere.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_wr_req) begin
                    state_nxt = WRITE;
                end else if (d_miss || i_miss) begin
                    state_nxt = FILL;
                end
            end
            WRITE: state_nxt = IDLE;
            FILL: begin
                if (mem_valid && recv_cnt == LAST_WORD) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winning request in IDLE; run issue/receive counters in FILL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= REQ_I;
            base_addr  <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            issue_cnt  <= '0;
            issue_done <= 1'b0;
            recv_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    issue_cnt  <= '0;
                    issue_done <= 1'b0;
                    recv_cnt   <= '0;
                    if (d_wr_req) begin
                        wr_addr <= d_wr_addr;
                        wr_data <= d_wr_data;
                    end else if (d_miss) begin
                        grant     <= REQ_D;
                        base_addr <= d_miss_addr & ADDR_MASK;
                    end else if (i_miss) begin
                        grant     <= REQ_I;
                        base_addr <= i_miss_addr & ADDR_MASK;
                    end
                end
                FILL: begin
                    // Issue side stops after the last word instead of wrapping.
                    if (!issue_done) begin
                        issue_cnt <= issue_cnt + 3'd1;
                        if (issue_cnt == LAST_WORD) begin
                            issue_done <= 1'b1;
                        end
                    end
                    if (mem_valid) begin
                        recv_cnt <= recv_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state; fill port passes returning data through.
    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_we     = 1'b0;
        fill_sel    = 1'b0;
        fill_word   = '0;
        fill_data   = '0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_wr_ack    = 1'b0;
        busy        = (state != IDLE);
        case (state)
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                d_wr_ack  = 1'b1;
            end
            FILL: begin
                if (!issue_done) begin
                    mem_en   = 1'b1;
                    mem_addr = base_addr | ADDR_W'({issue_cnt, 1'b0});
                end
                if (mem_valid) begin
                    fill_we   = 1'b1;
                    fill_sel  = (grant == REQ_D);
                    fill_word = recv_cnt;
                    fill_data = mem_rdata;
                end
            end
            DONE: begin
                i_fill_done = (grant == REQ_I);
                d_fill_done = (grant == REQ_D);
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single multi-cycle main memory between the I-cache miss path (FETCH), the D-cache miss path and the D-side write-through store path (MEMORY). It sequences 8-word block fills with pipelined reads, streams returned words into the requesting cache's data array, and pulses a done strobe so the cache can update its tag and drop its miss.

## Interface
- MEM_LAT, 4: cycles from read issue (mem_en=1, mem_wr=0) to mem_valid/mem_rdata.
- WORDS_PER_BLK, 8: 16-bit words per cache block (16-byte block).
- ADDR_W, 16: byte-address width.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_miss  in  1  I-cache miss, level, held until i_fill_done.
- i_miss_addr  in  ADDR_W  I-side miss byte address.
- d_miss  in  1  D-cache miss, level, held until d_fill_done.
- d_miss_addr  in  ADDR_W  D-side miss byte address.
- d_wr_req  in  1  write-through store request, held until d_wr_ack.
- d_wr_addr  in  ADDR_W  store byte address.
- d_wr_data  in  16  store data.
- mem_en, mem_wr  out  1 each  memory enable / write.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_valid  in  1  mem_rdata valid this cycle.
- fill_we  out  1  write fill_data into the selected cache's data array.
- fill_sel  out  1  0 = I-cache, 1 = D-cache.
- fill_word  out  3  word index within block.
- fill_data  out  16  word to write.
- i_fill_done, d_fill_done  out  1 each  one-cycle completion pulses.
- d_wr_ack  out  1  one-cycle store completion pulse.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, WRITE, FILL, DONE.
- IDLE priority: d_wr_req > d_miss > i_miss. Winner latched (grant, block base = addr & 16'hFFF0, or store addr/data). Next state WRITE or FILL; no request stays IDLE.
- WRITE: one cycle, mem_en=mem_wr=1, mem_addr/mem_wdata from latched store, d_wr_ack=1; -> IDLE.
- FILL: issue counter 0..7 issues one read per cycle, mem_addr = base | (issue_cnt<<1); receive counter increments on each mem_valid; on mem_valid: fill_we=1, fill_word=recv_cnt, fill_data=mem_rdata, fill_sel=grant. After receive count reaches 8 -> DONE.
- DONE: one cycle; pulse i_fill_done or d_fill_done per grant; -> IDLE.
- No preemption: a request arriving during WRITE/FILL/DONE waits until IDLE.
- Requester dropping its miss mid-fill (flush): fill still completes, done still pulses.
- mem_valid outside FILL ignored (no fill_we).
- Counters are 3-bit plus terminal flag; no wrap beyond 8 issues.

## Timing
- Reset: state IDLE; mem_en, mem_wr, fill_we, fill_sel, *_done, d_wr_ack, busy = 0; mem_addr, mem_wdata, fill_word, fill_data = 0; counters cleared. Reset mid-op aborts immediately; in-flight returns ignored.
- Miss seen in IDLE at cycle 0: reads cycles 1–8, fill_we cycles 5–12, done pulse cycle 13, IDLE cycle 14 (penalty = MEM_LAT + WORDS_PER_BLK + 1).
- Store seen at cycle 0: memory write and d_wr_ack at cycle 1, IDLE at cycle 2.
- Back-to-back: IDLE always occupies one cycle between services (lets cache drop miss before re-arbitration).
- All outputs registered or decoded from registered state/counters; only fill_we/fill_data depend combinationally on mem_valid/mem_rdata.

## Structure
- mem_arb_pkg: state enum (IDLE, WRITE, FILL, DONE), requester enum (REQ_I=0, REQ_D=1), BLK_MASK = 16'hFFF0, default MEM_LAT/WORDS_PER_BLK.
- Single module; no sub-module required. Verification_tasks gains a verify_MEM_ARB task reusing the existing message-string style.

## Test plan
- i_miss at 0x1234 alone -> mem_addr 0x1230,0x1232..0x123E cycles 1–8; fill_we, fill_sel=0, fill_word 0..7 cycles 5–12; i_fill_done cycle 13 only.
- d_miss 0x2000 and i_miss 0x0040 same cycle -> D fills 0x2000–0x200E, d_fill_done cycle 13; I reads start cycle 15, i_fill_done cycle 27.
- d_wr_req 0x0100 data 0xBEEF while idle -> cycle 1 mem_en=mem_wr=1, mem_addr 0x0100, mem_wdata 0xBEEF, d_wr_ack=1; IDLE cycle 2.
- d_wr_req raised at cycle 3 of an I-fill -> no mem_wr until IDLE at 14; write and d_wr_ack at cycle 15.
- i_miss deasserted at cycle 6 of a fill -> all 8 fill_we still occur, i_fill_done at 13.
- rst_n low at cycle 7 of a fill, stray mem_valid cycles 8–12 -> all outputs 0, no fill_we; new d_miss after release serviced with standard 13-cycle timing.
